bcd_serial_sub: RTL and testbench
=================================

BCD_SERIAL_SUB -- requirements
Module: bcd_serial_sub

Interface
REQ-001 SHALL have parameter: NDIGITS, 4, number of BCD digits per operand (2..8).
REQ-002 SHALL have port: clk  in  1  single clock; all state on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  in  1  begin a subtraction when idle.
REQ-005 SHALL have port: in_valid  in  1  digit pair on a_digit/b9_digit is valid.
REQ-006 SHALL have port: in_ready  out  1  block accepts a digit pair this cycle.
REQ-007 SHALL have port: a_digit  in  4  minuend digit, LSD first.
REQ-008 SHALL have port: b9_digit  in  4  9's-complemented subtrahend digit from the upstream complement stage, LSD first.
REQ-009 SHALL have port: out_valid  out  1  out_digit is valid.
REQ-010 SHALL have port: out_ready  in  1  consumer accepts out_digit.
REQ-011 SHALL have port: out_digit  out  4  magnitude digit of A-B, LSD first.
REQ-012 SHALL have port: neg  out  1  result sign, 1 = A<B; valid from first out_valid until next start.
REQ-013 SHALL have port: done  out  1  one-cycle pulse after the last digit is emitted.
REQ-014 SHALL have port: err  out  1  sticky flag, an input digit >9 was accepted.
REQ-015 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCUM -> EMIT -> IDLE.
REQ-017 In IDLE, start=1 SHALL enter ACCUM next cycle, set carry=1 (10's complement), clear digit count, err and neg.
REQ-018 start SHALL be ignored when busy=1.
REQ-019 in_ready SHALL equal (state==ACCUM); a digit pair is consumed only when in_valid & in_ready.
REQ-020 Per consumed pair: s = a_digit + b9_digit + carry (5 bits); if s>9 then digit = s-10 and carry=1, else digit = s and carry=0; digit is stored in buffer[count].
REQ-021 Any a_digit or b9_digit >9 SHALL set err; the digit SHALL still be processed per REQ-020, truncated to 4 bits.
REQ-022 After NDIGITS pairs, SHALL enter EMIT next cycle with neg = ~carry; no in_ready gaps other than in_valid stalls.
REQ-023 In EMIT, out_valid=1 and the digit advances only on out_valid & out_ready; out_digit SHALL hold stable while stalled.
REQ-024 If neg=0, out_digit = buffer[i]; if neg=1, out_digit = BCD(9 - buffer[i] + c2), where c2 starts at 1 and propagates per REQ-020.
REQ-025 After the NDIGITS-th accepted output, SHALL return to IDLE with done=1 for exactly one cycle.
REQ-026 Digit-count and buffer indices SHALL NOT wrap; a transfer beyond NDIGITS cannot occur.
REQ-027 Latency SHALL be 1 cycle start->in_ready and 1 cycle last input->out_valid, with no stalls.

Reset
REQ-028 rst_n=0 SHALL force IDLE, in_ready=0, out_valid=0, out_digit=0, neg=0, done=0, err=0, busy=0, carry=0, count=0, at any time including mid-operation.
REQ-029 After reset release, SHALL remain idle until a new start.

Structure
REQ-030 A shared package SHALL hold the state enum, BCD_MAX=9 and BCD_BASE=10.
REQ-031 SHALL instantiate one combinational sub-module bcd_digit_adder (a, b, cin -> sum, cout), used for both REQ-020 and REQ-024.

Verification
REQ-032 A=0532, B=0127 (b9 LSD-first 2,7,8,9; a 2,3,5,0) -> out 5,0,4,0, neg=0, done pulse.
REQ-033 A=0127, B=0532 (b9 7,6,4,9; a 7,2,1,0) -> buffer 9595, neg=1, out 5,0,4,0.
REQ-034 A=B=1234 -> out 0,0,0,0, neg=0; A=9999, B=0000 -> out 9,9,9,9, neg=0.
REQ-035 Random in_valid gaps and out_ready stalls on REQ-032 -> identical digits, out_digit stable during stalls, start while busy ignored.
REQ-036 rst_n low mid-ACCUM and mid-EMIT -> all outputs 0 immediately; the next run gives the correct result. A digit 0xB on input -> err=1 until the next start.

Source files
------------

// File: rtl/bcd_serial_sub_pkg.sv
// ============================================================================
// Module   : bcd_serial_sub_pkg
// Purpose  : Shared types and constants for the serial BCD subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_serial_sub_pkg;

   localparam int BCD_MAX  = 9;
   localparam int BCD_BASE = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   function automatic logic is_bad_digit(input logic [3:0] d);
      return d > 4'(BCD_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_serial_sub_if.sv
// ============================================================================
// Module   : bcd_serial_sub_if
// Purpose  : Digit-stream handshake and status bundle of the BCD subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_serial_sub_if;

   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a_digit;
   logic [3:0] b9_digit;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_digit;
   logic       neg;
   logic       done;
   logic       err;
   logic       busy;

   modport master (
      output start, in_valid, a_digit, b9_digit, out_ready,
      input  in_ready, out_valid, out_digit, neg, done, err, busy
   );

   modport slave (
      input  start, in_valid, a_digit, b9_digit, out_ready,
      output in_ready, out_valid, out_digit, neg, done, err, busy
   );

endinterface

`default_nettype wire

// File: rtl/bcd_digit_adder.sv
// ============================================================================
// Module   : bcd_digit_adder
// Purpose  : One-digit BCD adder with decimal carry correction.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder
   import bcd_serial_sub_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] raw;

   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (raw > 5'(BCD_MAX)) begin
         sum  = 4'(raw - 5'(BCD_BASE));
         cout = 1'b1;
      end else begin
         sum  = raw[3:0];
         cout = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_sub.sv
// ============================================================================
// Module   : bcd_serial_sub
// Purpose  : Serial LSD-first BCD subtractor (A + 9's(B) + 1), sign-magnitude out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_sub
   import bcd_serial_sub_pkg::*;
#(
   parameter int NDIGITS = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   bcd_serial_sub_if.slave  bus
);

   localparam int CW = $clog2(NDIGITS);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   count;
   logic            carry;
   logic            c2;
   logic            neg_flag;
   logic            err_flag;
   logic            done_pulse;
   logic [3:0]      buffer [NDIGITS];

   logic            in_fire;
   logic            out_fire;
   logic            last;
   logic [3:0]      acc_sum;
   logic            acc_cout;
   logic [3:0]      cmp_sum;
   logic            cmp_cout;
   logic [3:0]      nines;
   logic [3:0]      out_sel;

   assign in_fire  = (state == ACCUM) && bus.in_valid;
   assign out_fire = (state == EMIT) && bus.out_ready;
   assign last     = (count == CW'(NDIGITS - 1));

   bcd_digit_adder u_acc_adder (
      .a    (bus.a_digit),
      .b    (bus.b9_digit),
      .cin  (carry),
      .sum  (acc_sum),
      .cout (acc_cout)
   );

   // A negative difference arrives as a 10's complement; re-complement it.
   assign nines = 4'(BCD_MAX) - buffer[count];

   bcd_digit_adder u_cmp_adder (
      .a    (nines),
      .b    (4'd0),
      .cin  (c2),
      .sum  (cmp_sum),
      .cout (cmp_cout)
   );

   assign out_sel = neg_flag ? cmp_sum : buffer[count];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start)      state_nxt = ACCUM;
         ACCUM:   if (in_fire && last)  state_nxt = EMIT;
         EMIT:    if (out_fire && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == ACCUM);
      bus.out_valid = (state == EMIT);
      bus.busy      = (state != IDLE);
      bus.out_digit = (state == EMIT) ? out_sel : 4'd0;
      bus.neg       = neg_flag;
      bus.err       = err_flag;
      bus.done      = done_pulse;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         carry      <= 1'b0;
         c2         <= 1'b0;
         neg_flag   <= 1'b0;
         err_flag   <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  carry    <= 1'b1;
                  count    <= '0;
                  err_flag <= 1'b0;
                  neg_flag <= 1'b0;
               end
            end
            ACCUM: begin
               if (in_fire) begin
                  carry <= acc_cout;
                  if (is_bad_digit(bus.a_digit) || is_bad_digit(bus.b9_digit)) begin
                     err_flag <= 1'b1;
                  end
                  if (last) begin
                     count    <= '0;
                     c2       <= 1'b1;
                     neg_flag <= ~acc_cout;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            EMIT: begin
               if (out_fire) begin
                  c2 <= cmp_cout;
                  if (last) begin
                     count      <= '0;
                     done_pulse <= 1'b1;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

   // Digit storage carries no reset; it is always written before being read.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         buffer[count] <= acc_sum;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_sub.sv
// ============================================================================
// Module   : tb_bcd_serial_sub
// Purpose  : Self-checking bench for bcd_serial_sub against an integer model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_sub;

   localparam int N = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   bcd_serial_sub_if bus ();

   bcd_serial_sub #(.NDIGITS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
      end
   endtask

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic int digit_of(input int v, input int k);
      return (v / pow10(k)) % 10;
   endfunction

   task automatic clear_inputs();
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_digit   = 4'd0;
      bus.b9_digit  = 4'd0;
      bus.out_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_in_ready"},  bus.in_ready,  1'b0);
      check1({tag, "_out_valid"}, bus.out_valid, 1'b0);
      check4({tag, "_out_digit"}, bus.out_digit, 4'd0);
      check1({tag, "_neg"},       bus.neg,       1'b0);
      check1({tag, "_done"},      bus.done,      1'b0);
      check1({tag, "_err"},       bus.err,       1'b0);
      check1({tag, "_busy"},      bus.busy,      1'b0);
   endtask

   // Asynchronous reset pulse started between clock edges.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check1({tag, "_stay_idle"}, bus.busy, 1'b0);
      end
   endtask

   task automatic run_sub(input int a_val, input int b_val, input bit gaps,
                          input bit stalls, input bit poke_start,
                          input int abort_in, input int abort_out);
      int  mag;
      bit  exp_neg;
      exp_neg = (a_val < b_val);
      mag     = exp_neg ? (b_val - a_val) : (a_val - b_val);

      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = poke_start;
      check1("start_to_ready", bus.in_ready, 1'b1);
      check1("busy_accum",     bus.busy,     1'b1);
      check1("err_cleared",    bus.err,      1'b0);
      check1("neg_cleared",    bus.neg,      1'b0);

      for (int i = 0; i < N; i++) begin
         if (i == abort_in) begin
            async_reset("rst_accum");
            return;
         end
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               bus.in_valid = 1'b0;
               check1("ready_in_gap", bus.in_ready, 1'b1);
               @(negedge clk);
            end
         end
         bus.in_valid = 1'b1;
         bus.a_digit  = 4'(digit_of(a_val, i));
         bus.b9_digit = 4'(9 - digit_of(b_val, i));
         check1("in_ready", bus.in_ready, 1'b1);
         check1("no_early_out", bus.out_valid, 1'b0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check1("last_in_to_out_valid", bus.out_valid, 1'b1);
      check1("ready_low_emit",       bus.in_ready,  1'b0);

      for (int j = 0; j < N; j++) begin
         if (j == abort_out) begin
            async_reset("rst_emit");
            return;
         end
         if (stalls) begin
            repeat ($urandom_range(0, 3)) begin
               bus.out_ready = 1'b0;
               check1("valid_stall", bus.out_valid, 1'b1);
               check4("digit_stable", bus.out_digit, 4'(digit_of(mag, j)));
               @(negedge clk);
            end
         end
         if (j == N - 1) bus.start = 1'b0;
         bus.out_ready = 1'b1;
         check1("out_valid", bus.out_valid, 1'b1);
         check4("out_digit", bus.out_digit, 4'(digit_of(mag, j)));
         check1("neg",       bus.neg,       exp_neg);
         check1("no_early_done", bus.done,  1'b0);
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      check1("done_pulse",    bus.done,      1'b1);
      check1("busy_idle",     bus.busy,      1'b0);
      check1("valid_idle",    bus.out_valid, 1'b0);
      check4("digit_idle",    bus.out_digit, 4'd0);
      check1("neg_held",      bus.neg,       exp_neg);
      @(negedge clk);
      check1("done_one_cycle", bus.done,     1'b0);
      check1("still_idle",     bus.busy,     1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check1("idle_after_reset", bus.busy, 1'b0);

      run_sub(532,  127,  0, 0, 0, -1, -1);
      run_sub(127,  532,  0, 0, 0, -1, -1);
      run_sub(1234, 1234, 0, 0, 0, -1, -1);
      run_sub(9999, 0,    0, 0, 0, -1, -1);
      run_sub(0,    9999, 0, 0, 0, -1, -1);

      repeat (3) run_sub(532, 127, 1, 1, 1, -1, -1);

      run_sub(127, 532, 0, 0, 0, 2, -1);
      run_sub(127, 532, 0, 0, 0, -1, -1);
      run_sub(127, 532, 0, 1, 0, -1, 2);
      run_sub(532, 127, 1, 1, 0, -1, -1);

      // Out-of-range digit sets a sticky error that survives until next start.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.a_digit  = (i == 1) ? 4'hB : 4'd1;
         bus.b9_digit = 4'd8;
         @(negedge clk);
         if (i == 0) check1("err_before_bad", bus.err, 1'b0);
         if (i == 1) check1("err_set", bus.err, 1'b1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (N) @(negedge clk);
      bus.out_ready = 1'b0;
      check1("err_done_pulse", bus.done, 1'b1);
      check1("err_sticky",     bus.err,  1'b1);
      @(negedge clk);
      check1("err_sticky_idle", bus.err, 1'b1);
      run_sub(4321, 1234, 0, 0, 0, -1, -1);

      for (int k = 0; k < 20; k++) begin
         run_sub(int'($urandom_range(0, 9999)), int'($urandom_range(0, 9999)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

`default_nettype wire
